// File: rtl/mux_10_if.sv
// Data/select bundle for the registered 10-to-1 word multiplexer.
// The master drives the words and select code; the slave returns y and sel_err.
interface mux_10_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] d4;
    logic [WIDTH-1:0] d5;
    logic [WIDTH-1:0] d6;
    logic [WIDTH-1:0] d7;
    logic [WIDTH-1:0] d8;
    logic [WIDTH-1:0] d9;
    logic [3:0]       s;
    logic [WIDTH-1:0] y;
    logic             sel_err;

    modport master (
        output d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, s,
        input  y, sel_err
    );

    modport slave (
        input  d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, s,
        output y, sel_err
    );
endinterface

// File: rtl/mux_10.sv
// Registered 10-to-1 word multiplexer with an out-of-range select flag.
// One-cycle latency; the output register loads on every clock.
module mux_10 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_10_if.slave  bus
);
    localparam int unsigned SEL_W = 4;

    logic [WIDTH-1:0] y_q;
    logic             sel_err_q;
    logic [WIDTH-1:0] y_c;
    logic             sel_err_c;

    // Select decode; codes 10..15 and any X/Z on s land in the default branch.
    always_comb begin
        y_c       = '0;
        sel_err_c = 1'b0;
        case (bus.s)
            SEL_W'(0): y_c = bus.d0;
            SEL_W'(1): y_c = bus.d1;
            SEL_W'(2): y_c = bus.d2;
            SEL_W'(3): y_c = bus.d3;
            SEL_W'(4): y_c = bus.d4;
            SEL_W'(5): y_c = bus.d5;
            SEL_W'(6): y_c = bus.d6;
            SEL_W'(7): y_c = bus.d7;
            SEL_W'(8): y_c = bus.d8;
            SEL_W'(9): y_c = bus.d9;
            default: begin
                y_c       = '0;
                sel_err_c = 1'b1;
            end
        endcase
    end

    // Output register; synchronous reset wins over the decoded value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            sel_err_q <= 1'b0;
        end else begin
            y_q       <= y_c;
            sel_err_q <= sel_err_c;
        end
    end

    assign bus.y       = y_q;
    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_10.sv
// Directed bench for mux_10: reset, select sweep, out-of-range codes,
// data tracking, mid-stream reset and absence of combinational paths.
module tb_mux_10;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [WIDTH-1:0] prev_y;
    logic             prev_err;
    logic [WIDTH-1:0] sweep_d [10];
    logic [WIDTH-1:0] sweep_e [10];

    mux_10_if #(.WIDTH(WIDTH)) bus ();

    mux_10 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_y(input string tag, input logic [WIDTH-1:0] exp_y);
        checks++;
        assert (bus.y === exp_y) else begin
            errors++;
            $error("FAIL %s: y=%h expected %h", tag, bus.y, exp_y);
        end
    endtask

    task automatic check_err(input string tag, input logic exp_err);
        checks++;
        assert (bus.sel_err === exp_err) else begin
            errors++;
            $error("FAIL %s: sel_err=%b expected %b", tag, bus.sel_err, exp_err);
        end
    endtask

    // Apply s (data already set by caller), confirm outputs hold until the edge,
    // then confirm the registered result one edge later.
    task automatic step(input string tag, input logic [3:0] sel, input logic rst_v,
                        input logic [WIDTH-1:0] exp_y, input logic exp_err);
        bus.s = sel;
        rst_n = rst_v;
        #2;
        check_y({tag, "_hold_y"}, prev_y);
        check_err({tag, "_hold_err"}, prev_err);
        @(posedge clk);
        #1;
        check_y(tag, exp_y);
        check_err(tag, exp_err);
        prev_y   = exp_y;
        prev_err = exp_err;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sweep_d = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
                    16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        sweep_e = sweep_d;
        bus.d0 = sweep_d[0]; bus.d1 = sweep_d[1]; bus.d2 = sweep_d[2];
        bus.d3 = sweep_d[3]; bus.d4 = sweep_d[4]; bus.d5 = sweep_d[5];
        bus.d6 = sweep_d[6]; bus.d7 = sweep_d[7]; bus.d8 = sweep_d[8];
        bus.d9 = sweep_d[9];
        bus.s  = 4'd3;
        rst_n  = 1'b0;

        // Reset: two edges with s=3
        @(posedge clk); #1;
        check_y("reset1", 16'h0000);
        check_err("reset1", 1'b0);
        @(posedge clk); #1;
        check_y("reset2", 16'h0000);
        check_err("reset2", 1'b0);
        prev_y   = 16'h0000;
        prev_err = 1'b0;

        // Sweep s=0..9
        for (int i = 0; i < 10; i++) begin
            step($sformatf("sweep_s%0d", i), 4'(i), 1'b1, sweep_e[i], 1'b0);
        end

        // Out-of-range codes, then recovery
        step("oor_A", 4'hA, 1'b1, 16'h0000, 1'b1);
        step("oor_F", 4'hF, 1'b1, 16'h0000, 1'b1);
        step("recover_s2", 4'd2, 1'b1, 16'h000C, 1'b0);

        // Data tracking on s=5
        step("track_s5", 4'd5, 1'b1, 16'h000F, 1'b0);
        bus.d5 = 16'hBEEF;
        step("track_d5", 4'd5, 1'b1, 16'hBEEF, 1'b0);
        bus.d4 = 16'h1234;
        step("track_d4", 4'd5, 1'b1, 16'hBEEF, 1'b0);
        bus.d6 = 16'h5678;
        step("track_d6", 4'd5, 1'b1, 16'hBEEF, 1'b0);

        // Reset mid-stream while s=7, then release
        step("midrst", 4'd7, 1'b0, 16'h0000, 1'b0);
        step("release", 4'd7, 1'b1, 16'h0002, 1'b0);

        // Reset clears a pending error flag
        step("err_set", 4'hC, 1'b1, 16'h0000, 1'b1);
        step("err_rst", 4'hC, 1'b0, 16'h0000, 1'b0);
        step("sel9", 4'd9, 1'b1, 16'h0004, 1'b0);

        // Back-to-back changes of s with fresh data every cycle
        bus.d0 = 16'hFFFF;
        step("b2b_s0", 4'd0, 1'b1, 16'hFFFF, 1'b0);
        bus.d8 = 16'h8001;
        step("b2b_s8", 4'd8, 1'b1, 16'h8001, 1'b0);
        step("b2b_sB", 4'hB, 1'b1, 16'h0000, 1'b1);
        step("b2b_s1", 4'd1, 1'b1, 16'h000B, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
